dm_cache_mem_resp: RTL

DM_CACHE_MEM_RESP -- requirements
Module: dm_cache_mem_resp

---
 rtl/dm_cache_mem_resp.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/dm_cache_mem_resp.sv
// dm_cache_mem_resp: behavioural backing memory for a direct-mapped cache.
// Accepts one line request at a time, waits a programmable latency and then
// returns the line with a one-cycle ready pulse.
// Optional build macro MEM_RESP_JITTER_EN adds 0..3 cycles of LFSR-driven
// latency jitter per request; without it the latency is exactly LAT.

package dm_cache_mem_resp_pkg;

  // Request from the cache: rw = 1 means write.
  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  // Response to the cache: data is meaningful only while ready = 1.
  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

endpackage

// Handshake: the cache raises mem_req.valid for one cycle with a request.
// A request is taken on any rising edge where the FSM is in IDLE or RESP
// (RESP is its last cycle, so a new request there starts with no gap).
// A valid seen while in WAIT is dropped and latches proto_err until reset.
// mem_data.ready pulses for one cycle per accepted request; mem_data.data is
// registered and stable during that cycle.
module dm_cache_mem_resp
  import dm_cache_mem_resp_pkg::*;
#(
  parameter int LAT        = 4,
  parameter int LINES_LOG2 = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data,
  output logic         busy,
  output logic         proto_err,
  output logic [1:0]   dbg_state_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Wide enough for LAT-1 (max 14) plus up to 3 jitter cycles.
  localparam int CW = 5;
  localparam logic [CW-1:0] LOAD_BASE = CW'(LAT - 1);
  localparam int LINES = 1 << LINES_LOG2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LINES_LOG2-1:0] hold_idx_q, hold_idx_d;
  logic [127:0]          hold_data_q, hold_data_d;
  logic                  hold_rw_q, hold_rw_d;
  logic                  ready_q;
  logic [127:0]          data_q;
  logic                  proto_err_q, proto_err_d;

  logic [127:0]          store_q [0:LINES-1];

  logic [LINES_LOG2-1:0] req_idx;
  logic [CW-1:0]         jitter;
  logic [CW-1:0]         load_val;
  logic                  go_resp;
  logic [LINES_LOG2-1:0] sel_idx;
  logic [127:0]          sel_data;
  logic                  sel_rw;

  // Line index comes from addr[LINES_LOG2+3:4]; the byte offset and the
  // bits above the store size alias onto the same line.
  assign req_idx = mem_req.addr[LINES_LOG2+3:4];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req.addr[31:LINES_LOG2+4], mem_req.addr[3:0]};

`ifdef MEM_RESP_JITTER_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;

  // Fibonacci taps 8,6,5,4 (bits 7,5,4,3).
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Free-running LFSR; its low two bits pick the extra delay for a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 8'h5A;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
  end

  assign jitter = {{(CW-2){1'b0}}, lfsr_q[1:0]};
`else
  assign jitter = '0;
`endif

  assign load_val = LOAD_BASE + jitter;

  // Next-state logic: accept in IDLE/RESP, count down in WAIT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_idx_d  = hold_idx_q;
    hold_data_d = hold_data_q;
    hold_rw_d   = hold_rw_q;
    proto_err_d = proto_err_q;
    go_resp     = 1'b0;
    sel_idx     = hold_idx_q;
    sel_data    = hold_data_q;
    sel_rw      = hold_rw_q;

    case (state_q)
      IDLE, RESP: begin
        if (mem_req.valid) begin
          hold_idx_d  = req_idx;
          hold_data_d = mem_req.data;
          hold_rw_d   = mem_req.rw;
          cnt_d       = load_val;
          if (load_val != '0) begin
            state_d = WAIT;
          end else begin
            // Zero countdown: respond straight away using the incoming request.
            state_d  = RESP;
            go_resp  = 1'b1;
            sel_idx  = req_idx;
            sel_data = mem_req.data;
            sel_rw   = mem_req.rw;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (mem_req.valid) begin
          proto_err_d = 1'b1;
        end
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control, holding and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_idx_q  <= '0;
      hold_data_q <= '0;
      hold_rw_q   <= 1'b0;
      ready_q     <= 1'b0;
      data_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_idx_q  <= hold_idx_d;
      hold_data_q <= hold_data_d;
      hold_rw_q   <= hold_rw_d;
      ready_q     <= go_resp;
      proto_err_q <= proto_err_d;
      if (go_resp) begin
        // A write echoes the line it stores; a read returns the stored line.
        data_q <= sel_rw ? sel_data : store_q[sel_idx];
      end
    end
  end

  // Backing store is not reset; a write lands on the edge that enters RESP,
  // so a reset during WAIT drops it.
  always_ff @(posedge clk) begin
    if (go_resp && sel_rw && !rst) begin
      store_q[sel_idx] <= sel_data;
    end
  end

  assign mem_data.ready = ready_q;
  assign mem_data.data  = data_q;
  assign busy           = (state_q != IDLE);
  assign proto_err      = proto_err_q;
  assign dbg_state_o    = state_q;

endmodule
